// File: rtl/pic_int_sequencer_pkg.sv
// Shared types and helpers for the 8259 interrupt sequencer.
// Level indices are 3 bits wide; priority arithmetic wraps modulo 8.
package pic_pkg;
   localparam int NUM_IR = 8;
   localparam int LVL_W  = 3;
   localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

   typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_t;

   function automatic logic [NUM_IR-1:0] onehot3to8(input logic [LVL_W-1:0] lvl);
      return 8'b0000_0001 << lvl;
   endfunction

   // 0 = highest priority under the given rotation.
   function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] lvl,
                                                  input logic [LVL_W-1:0] lowest_prio);
      return lvl - lowest_prio - 3'd1;
   endfunction
endpackage

// File: rtl/pic_int_sequencer_priority_resolver.sv
// Rotating priority encoder: finds the highest-priority set bit of vec, where
// level (lowest_prio+1) mod 8 ranks first. Purely combinational.
module pic_priority_resolver
   import pic_pkg::*;
(
   input  logic [NUM_IR-1:0] vec,
   input  logic [LVL_W-1:0]  lowest_prio,
   output logic              found,
   output logic [LVL_W-1:0]  lvl
);
   logic [LVL_W-1:0] idx;

   always_comb begin
      found = |vec;
      lvl   = '0;
      idx   = '0;
      // Walk from lowest to highest priority so the last hit is the winner.
      for (int i = NUM_IR - 1; i >= 0; i--) begin
         idx = lowest_prio + LVL_W'(i + 1);
         if (vec[idx]) lvl = idx;
      end
   end
endmodule

// File: rtl/pic_int_sequencer.sv
// 8259 control sequencer: resolves masked IRR against ISR, raises INT one clk
// after a winning request, runs the two-pulse INTA handshake and EOI/AEOI.
module pic_int_sequencer
   import pic_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IR-1:0]   irr_in,
   input  logic [NUM_IR-1:0]   imr,
   input  logic [4:0]          vector_base,
   input  logic                aeoi,
   input  logic                rotate_aeoi,
   input  logic                eoi_valid,
   input  logic                eoi_specific,
   input  logic [LVL_W-1:0]    eoi_level,
   input  logic                eoi_rotate,
   input  logic                inta_n,
   output logic                int_out,
   output logic [NUM_IR-1:0]   clear_irr,
   output logic [NUM_IR-1:0]   isr,
   output logic [7:0]          data_out,
   output logic                data_out_en
);
   state_t              state_q, state_d;
   logic                int_out_q, int_out_d;
   logic [NUM_IR-1:0]   clear_irr_q, clear_irr_d;
   logic [NUM_IR-1:0]   isr_q, isr_d;
   logic [7:0]          data_out_q, data_out_d;
   logic                data_out_en_q, data_out_en_d;
   logic [LVL_W-1:0]    lowest_prio_q, lowest_prio_d;
   logic [LVL_W-1:0]    lvl_q, lvl_d;
   logic                spur_q, spur_d;
   logic                inta_q;

   logic [NUM_IR-1:0]   eligible, eoi_mask;
   logic                req_found, isr_found, req_ok, fall, rise;
   logic [LVL_W-1:0]    req_lvl, isr_lvl;

   assign eligible = irr_in & ~imr;
   assign fall     = inta_q & ~inta_n;
   assign rise     = ~inta_q & inta_n;

   pic_priority_resolver u_req_res (
      .vec(eligible), .lowest_prio(lowest_prio_q), .found(req_found), .lvl(req_lvl)
   );

   pic_priority_resolver u_isr_res (
      .vec(isr_q), .lowest_prio(lowest_prio_q), .found(isr_found), .lvl(isr_lvl)
   );

   // Fully nested: a request must strictly outrank the top in-service level.
   assign req_ok = req_found &&
                   (!isr_found || (prio_rank(req_lvl, lowest_prio_q) < prio_rank(isr_lvl, lowest_prio_q)));

   always_comb begin
      state_d       = state_q;
      int_out_d     = int_out_q;
      clear_irr_d   = '0;
      data_out_d    = data_out_q;
      data_out_en_d = data_out_en_q;
      lowest_prio_d = lowest_prio_q;
      lvl_d         = lvl_q;
      spur_d        = spur_q;
      eoi_mask      = '0;

      if (eoi_valid) begin
         if (eoi_specific) begin
            eoi_mask = onehot3to8(eoi_level);
            if (eoi_rotate) lowest_prio_d = eoi_level;
         end else if (isr_found) begin
            eoi_mask = onehot3to8(isr_lvl);
            if (eoi_rotate) lowest_prio_d = isr_lvl;
         end
      end
      // EOI acts on the pre-update ISR; a same-cycle set below wins.
      isr_d = isr_q & ~eoi_mask;

      case (state_q)
         IDLE: begin
            int_out_d = 1'b0;
            if (req_ok) begin
               int_out_d = 1'b1;
               state_d   = PEND;
            end
         end
         PEND: begin
            if (fall) begin
               int_out_d = 1'b0;
               state_d   = ACK1;
               if (req_ok) begin
                  lvl_d       = req_lvl;
                  spur_d      = 1'b0;
                  isr_d       = isr_d | onehot3to8(req_lvl);
                  clear_irr_d = onehot3to8(req_lvl);
               end else begin
                  lvl_d  = SPURIOUS_LVL;
                  spur_d = 1'b1;
               end
            end else if (!req_ok) begin
               int_out_d = 1'b0;
               state_d   = IDLE;
            end
         end
         ACK1: begin
            if (fall) begin
               data_out_d    = {vector_base, lvl_q};
               data_out_en_d = 1'b1;
               state_d       = ACK2;
            end
         end
         ACK2: begin
            if (rise) begin
               data_out_d    = '0;
               data_out_en_d = 1'b0;
               state_d       = IDLE;
               if (aeoi && !spur_q) begin
                  isr_d = isr_d & ~onehot3to8(lvl_q);
                  if (rotate_aeoi) lowest_prio_d = lvl_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         int_out_q     <= 1'b0;
         clear_irr_q   <= '0;
         isr_q         <= '0;
         data_out_q    <= '0;
         data_out_en_q <= 1'b0;
         lowest_prio_q <= 3'd7;
         lvl_q         <= '0;
         spur_q        <= 1'b0;
         inta_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         int_out_q     <= int_out_d;
         clear_irr_q   <= clear_irr_d;
         isr_q         <= isr_d;
         data_out_q    <= data_out_d;
         data_out_en_q <= data_out_en_d;
         lowest_prio_q <= lowest_prio_d;
         lvl_q         <= lvl_d;
         spur_q        <= spur_d;
         inta_q        <= inta_n;
      end
   end

   assign int_out     = int_out_q;
   assign clear_irr   = clear_irr_q;
   assign isr         = isr_q;
   assign data_out    = data_out_q;
   assign data_out_en = data_out_en_q;
endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed bench for pic_int_sequencer; inputs change 1ns after posedge and
// outputs are sampled there too, reflecting the edge just taken.
module tb_pic_int_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] irr_in = '0, imr = '0;
   logic [4:0] vector_base = 5'h11;
   logic       aeoi = 1'b0, rotate_aeoi = 1'b0;
   logic       eoi_valid = 1'b0, eoi_specific = 1'b0, eoi_rotate = 1'b0;
   logic [2:0] eoi_level = '0;
   logic       inta_n = 1'b1;
   logic       int_out, data_out_en;
   logic [7:0] clear_irr, isr, data_out;
   int checks = 0;
   int errors = 0;

   pic_int_sequencer dut (
      .clk(clk), .rst(rst), .irr_in(irr_in), .imr(imr), .vector_base(vector_base),
      .aeoi(aeoi), .rotate_aeoi(rotate_aeoi), .eoi_valid(eoi_valid),
      .eoi_specific(eoi_specific), .eoi_level(eoi_level), .eoi_rotate(eoi_rotate),
      .inta_n(inta_n), .int_out(int_out), .clear_irr(clear_irr), .isr(isr),
      .data_out(data_out), .data_out_en(data_out_en)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; inta_n = 1'b1; irr_in = '0; imr = '0;
      tick(); tick();
      rst = 1'b1;
   endtask

   task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
      eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl; eoi_rotate = rot;
      tick();
      eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
   endtask

   // Full two-pulse INTA starting in PEND; irr_after models the IRR clearing.
   task automatic serve(input logic [7:0] irr_after);
      inta_n = 1'b0; tick();
      irr_in = irr_after; inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      inta_n = 1'b1; tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", int_out); end
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h want 00", isr); end
      checks++; if ({data_out_en, data_out, clear_irr} !== 17'h0) begin errors++;
         $display("FAIL reset_bus: got en=%b data=%h clr=%h want 0", data_out_en, data_out, clear_irr); end
   endtask

   task automatic test_single();
      irr_in = 8'h08; tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL single_int: got %b want 1", int_out); end
      inta_n = 1'b0; tick();
      checks++; if (clear_irr !== 8'h08) begin errors++; $display("FAIL single_clr: got %h want 08", clear_irr); end
      checks++; if (isr !== 8'h08) begin errors++; $display("FAIL single_isr: got %h want 08", isr); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL single_int_drop: got %b want 0", int_out); end
      irr_in = 8'h00; tick();
      checks++; if (clear_irr !== 8'h00) begin errors++; $display("FAIL single_clr_pulse: got %h want 00", clear_irr); end
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      checks++; if (data_out !== 8'h8B || data_out_en !== 1'b1) begin errors++;
         $display("FAIL single_vec: got %h en=%b want 8b en=1", data_out, data_out_en); end
      tick();
      checks++; if (data_out_en !== 1'b1) begin errors++; $display("FAIL single_vec_hold: got %b want 1", data_out_en); end
      inta_n = 1'b1; tick();
      checks++; if (data_out !== 8'h00 || data_out_en !== 1'b0) begin errors++;
         $display("FAIL single_vec_end: got %h en=%b want 00 en=0", data_out, data_out_en); end
      checks++; if (isr !== 8'h08) begin errors++; $display("FAIL single_isr_keep: got %h want 08", isr); end
   endtask

   task automatic test_nesting();
      irr_in = 8'h20; tick(); tick();
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL nest_blocked: got %b want 0", int_out); end
      eoi(1'b0, 3'd0, 1'b0);
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL nest_eoi_isr: got %h want 00", isr); end
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL nest_int_after_eoi: got %b want 1", int_out); end
      serve(8'h00);
      checks++; if (isr !== 8'h20) begin errors++; $display("FAIL nest_isr5: got %h want 20", isr); end
      irr_in = 8'h02; tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL nest_higher_int: got %b want 1", int_out); end
      serve(8'h00);
      checks++; if (isr !== 8'h22) begin errors++; $display("FAIL nest_isr_both: got %h want 22", isr); end
      eoi(1'b0, 3'd0, 1'b0);
      checks++; if (isr !== 8'h20) begin errors++; $display("FAIL nest_nseoi_top: got %h want 20", isr); end
      eoi(1'b1, 3'd5, 1'b0);
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL nest_seoi: got %h want 00", isr); end
   endtask

   task automatic test_mask_rotate();
      do_reset();
      irr_in = 8'h81; imr = 8'h01; tick();
      inta_n = 1'b0; tick();
      checks++; if (clear_irr !== 8'h80) begin errors++; $display("FAIL mask_clr: got %h want 80", clear_irr); end
      irr_in = 8'h01; inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      checks++; if (data_out !== 8'h8F) begin errors++; $display("FAIL mask_vec: got %h want 8f", data_out); end
      inta_n = 1'b1; tick();
      eoi(1'b0, 3'd0, 1'b1);
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL rot_eoi_isr: got %h want 00", isr); end
      imr = 8'h00; irr_in = 8'h81; tick();
      inta_n = 1'b0; tick();
      checks++; if (clear_irr !== 8'h01) begin errors++; $display("FAIL rot_lvl0: got %h want 01", clear_irr); end
      irr_in = 8'h80; inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      checks++; if (data_out !== 8'h88) begin errors++; $display("FAIL rot_vec0: got %h want 88", data_out); end
      inta_n = 1'b1; tick();
      // Level 3 not in service: set-priority only, making level 4 highest.
      eoi(1'b1, 3'd3, 1'b1);
      checks++; if (isr !== 8'h01 || int_out !== 1'b0) begin errors++;
         $display("FAIL setprio_eoi: got isr=%h int=%b want 01 0", isr, int_out); end
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL setprio_int: got %b want 1", int_out); end
      // Same-cycle specific EOI on the bit being set: set wins.
      eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd7; inta_n = 1'b0; tick();
      eoi_valid = 1'b0; eoi_specific = 1'b0;
      checks++; if (clear_irr !== 8'h80 || isr !== 8'h81) begin errors++;
         $display("FAIL setwins: got clr=%h isr=%h want 80 81", clear_irr, isr); end
      irr_in = 8'h00; inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      inta_n = 1'b1; tick();
   endtask

   task automatic test_spurious();
      do_reset();
      irr_in = 8'h04; tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL spur_int: got %b want 1", int_out); end
      irr_in = 8'h00; inta_n = 1'b0; tick();
      checks++; if (clear_irr !== 8'h00 || isr !== 8'h00 || int_out !== 1'b0) begin errors++;
         $display("FAIL spur_ack1: got clr=%h isr=%h int=%b want 00 00 0", clear_irr, isr, int_out); end
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      checks++; if (data_out !== 8'h8F || data_out_en !== 1'b1) begin errors++;
         $display("FAIL spur_vec: got %h en=%b want 8f en=1", data_out, data_out_en); end
      inta_n = 1'b1; tick();
      checks++; if (data_out_en !== 1'b0 || isr !== 8'h00) begin errors++;
         $display("FAIL spur_end: got en=%b isr=%h want 0 00", data_out_en, isr); end
   endtask

   task automatic test_aeoi();
      do_reset();
      aeoi = 1'b1; rotate_aeoi = 1'b1;
      irr_in = 8'h04; tick();
      inta_n = 1'b0; tick();
      checks++; if (clear_irr !== 8'h04 || isr !== 8'h04) begin errors++;
         $display("FAIL aeoi_ack1: got clr=%h isr=%h want 04 04", clear_irr, isr); end
      irr_in = 8'h00; inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      checks++; if (data_out !== 8'h8A || isr !== 8'h04) begin errors++;
         $display("FAIL aeoi_ack2: got data=%h isr=%h want 8a 04", data_out, isr); end
      inta_n = 1'b1; tick();
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL aeoi_clear: got %h want 00", isr); end
      irr_in = 8'h0A; tick();
      inta_n = 1'b0; tick();
      checks++; if (clear_irr !== 8'h08) begin errors++; $display("FAIL aeoi_rot_lvl3: got %h want 08", clear_irr); end
      irr_in = 8'h02; inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      inta_n = 1'b1; tick();
      aeoi = 1'b0; rotate_aeoi = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      irr_in = 8'h01; tick();
      inta_n = 1'b0; tick();
      inta_n = 1'b1; rst = 1'b0; tick();
      checks++; if ({int_out, clear_irr, isr, data_out, data_out_en} !== 26'h0) begin errors++;
         $display("FAIL midrst_outs: got int=%b clr=%h isr=%h data=%h en=%b want all 0",
                  int_out, clear_irr, isr, data_out, data_out_en); end
      irr_in = 8'h00; rst = 1'b1; tick();
      inta_n = 1'b0; tick();
      checks++; if (clear_irr !== 8'h00 || isr !== 8'h00) begin errors++;
         $display("FAIL midrst_fall1: got clr=%h isr=%h want 00 00", clear_irr, isr); end
      inta_n = 1'b1; tick();
      inta_n = 1'b0; tick();
      checks++; if (data_out_en !== 1'b0 || data_out !== 8'h00 || int_out !== 1'b0) begin errors++;
         $display("FAIL midrst_fall2: got en=%b data=%h int=%b want 0 00 0", data_out_en, data_out, int_out); end
      inta_n = 1'b1; tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_nesting();
      test_mask_rotate();
      test_spurious();
      test_aeoi();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pic_int_sequencer.md
Name: pic_int_sequencer

Overview:
- Control block between the IRR and the CPU bus in the 8259 PIC.
- Masks and priority-resolves pending IRR bits against the in-service register (ISR), which it owns, and raises INT.
- Runs the two-pulse INTA acknowledge: clears the served IRR bit, sets ISR, drives the 8-bit vector.
- Handles EOI commands (non-specific, specific, rotate) and automatic-EOI mode.

Parameters:
- NUM_IR, 8, number of interrupt levels. Fixed at 8; level index width is 3.
- SPURIOUS_LVL, 7, level reported when an INTA finds no eligible request.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low. Sampled on clk; rst=0 resets all state.
- irr_in  input  8  current IRR contents.
- imr  input  8  interrupt mask; 1 = masked.
- vector_base  input  5  T7..T3 of vector (ICW2).
- aeoi  input  1  automatic-EOI mode.
- rotate_aeoi  input  1  rotate priority on automatic EOI.
- eoi_valid  input  1  one-cycle EOI command strobe.
- eoi_specific  input  1  1 = specific EOI; 0 = non-specific.
- eoi_level  input  3  target level for specific EOI.
- eoi_rotate  input  1  rotate priority on this EOI.
- inta_n  input  1  acknowledge, active-low, already synchronous to clk.
- int_out  output  1  interrupt request to CPU.
- clear_irr  output  8  one-hot, one-cycle pulse clearing the served IRR bit.
- isr  output  8  in-service register.
- data_out  output  8  vector byte.
- data_out_en  output  1  vector valid / bus drive enable.

Behaviour:
- Reset values:
  - int_out=0, clear_irr=0, isr=0, data_out=0, data_out_en=0.
  - lowest_prio=7 (IR0 highest), lvl_q=0, inta_q=1, state=IDLE.
- INTA edge detection: inta_q is inta_n registered. fall = inta_q & ~inta_n. rise = ~inta_q & inta_n.
- Priority order: level (lowest_prio+1) mod 8 is highest, then ascending with wrap.
- eligible = irr_in & ~imr. req_lvl = highest-priority set bit of eligible.
- req_ok is true when eligible≠0 and req_lvl outranks every set isr bit (fully nested). req_ok is combinational.
- State IDLE:
  - If req_ok: int_out←1 next cycle and go to PEND. INT latency is 1 clk from the IRR change.
- State PEND:
  - If !req_ok and no fall: int_out←0 and go to IDLE (request withdrawn).
  - On fall with req_ok: lvl_q←req_lvl; isr[req_lvl]←1; clear_irr←onehot(req_lvl) for exactly 1 cycle; int_out←0; go to ACK1.
  - On fall with !req_ok (spurious): lvl_q←SPURIOUS_LVL; no isr set; clear_irr stays 0; int_out←0; go to ACK1.
- State ACK1:
  - On fall: data_out←{vector_base,lvl_q}; data_out_en←1; go to ACK2.
  - If the first pulse is still low, ACK1 waits; only a new fall advances.
- State ACK2:
  - data_out_en holds 1 while inta_n low.
  - On rise: data_out_en←0; data_out←0.
  - If aeoi and not spurious: isr[lvl_q]←0; if rotate_aeoi, lowest_prio←lvl_q.
  - Go to IDLE. A pending req_ok re-raises int_out one cycle later.
- EOI (eoi_valid=1, any state):
  - Non-specific: clear the highest-priority set isr bit under the current rotation. No-op if isr==0.
  - Specific: clear isr[eoi_level]. No-op if that bit is already 0.
  - If eoi_rotate and a bit was cleared: lowest_prio←cleared level. Specific with eoi_rotate when the bit is already 0 still sets lowest_prio←eoi_level (set-priority semantics).
- Simultaneous EOI and ISR set in the same cycle: EOI is evaluated on the pre-update isr. If both target the same bit, the set wins.
- Rotation updates take effect on the next cycle's resolution.
- rst=0 at any point, including mid-INTA, forces all reset values. The sequence aborts and no clear_irr is issued.
- fall while in IDLE is ignored.

Decomposition:
- Package pic_pkg holds:
  - state enum IDLE/PEND/ACK1/ACK2.
  - NUM_IR=8 and LVL_W=3.
  - SPURIOUS_LVL.
  - onehot3to8 function.
- Sub-module pic_priority_resolver (combinational): inputs vec[7:0] and lowest_prio[2:0]; outputs found and lvl[2:0]. Instantiated twice: one for eligible, one for isr (non-specific EOI and nesting check).

Test Plan:
- Single request: irr_in=0x08, imr=0, vector_base=0x11.
  - int_out=1 one cycle later.
  - First INTA → clear_irr=0x08 for 1 clk, isr=0x08.
  - Second INTA → data_out=0x8B, data_out_en=1 until inta_n rises.
- Nesting: isr=0x08 (level 3) in service, irr_in=0x20 (level 5).
  - int_out stays 0.
  - Non-specific EOI → isr=0x00, then int_out=1.
- Masking and rotation, with irr_in=0x81:
  - imr=0x01 → level 7 served.
  - EOI with eoi_rotate → lowest_prio=7.
  - With imr=0, irr_in=0x81 then serves level 0.
- Spurious: int_out=1 for irr_in=0x04, then irr_in→0 as first INTA falls in the same cycle.
  - No clear_irr, isr unchanged.
  - Vector={vector_base,3'd7}.
- AEOI: aeoi=1, rotate_aeoi=1, serve level 2.
  - isr bit 2 cleared on second-INTA rise.
  - lowest_prio=2, so level 3 becomes highest.
- Reset mid-sequence: rst=0 in ACK1.
  - Next cycle: all outputs 0, isr=0, state IDLE.
  - A subsequent INTA fall is ignored.
